sprite_renderer: RTL and testbench
==================================

SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter H_RES, default 160, horizontal pixels per frame.
REQ-002 Parameter V_RES, default 120, vertical pixels per frame.
REQ-003 Parameter X_W, default 8, x coordinate width; Y_W, default 7, y coordinate width.
REQ-004 Parameter NUM_BOARDS, default 4, board object count (1..16).
REQ-005 Parameters MAN_W=4, MAN_H=6, BOARD_W=24, BOARD_H=2, object sizes in pixels.
REQ-006 Parameters MAN_COLOUR=3'b100, BOARD_COLOUR=3'b010, BG_COLOUR=3'b000, 3-bit RGB fills.
REQ-007 clk  in  1  system clock; all state on its rising edge.
REQ-008 resetn  in  1  asynchronous active-low reset.
REQ-009 run  in  1  level; 1 = render frames continuously.
REQ-010 man_x / man_y  in  X_W / Y_W  man top-left corner.
REQ-011 boards_x / boards_y  in  NUM_BOARDS*X_W / NUM_BOARDS*Y_W  packed board top-left corners, board i at slice i.
REQ-012 board_en  in  NUM_BOARDS  per-board visibility.
REQ-013 x / y  out  X_W / Y_W  pixel address to frame buffer.
REQ-014 colour  out  3  pixel colour.
REQ-015 plot  out  1  write strobe for x/y/colour.
REQ-016 frame_start / frame_done  out  1 / 1  single-cycle frame markers.

Function
REQ-017 FSM states: IDLE, LATCH, SCAN, DONE.
REQ-018 IDLE -> LATCH when run=1; else stay IDLE.
REQ-019 LATCH lasts exactly 1 cycle: snapshot all position inputs and board_en into shadow registers; frame_start=1 this cycle only; -> SCAN.
REQ-020 SCAN: counters cx, cy start 0,0; cx increments each cycle, wraps H_RES-1 -> 0 with cy+1; after (H_RES-1, V_RES-1) -> DONE.
REQ-021 Outputs registered, latency 1: cycle after each SCAN cycle, x=cx, y=cy, colour=shade(cx,cy), plot=1.
REQ-022 Exactly H_RES*V_RES plot pulses per frame, raster order, no gaps, no repeats.
REQ-023 DONE lasts 1 cycle: frame_done=1 (coincides with last pixel plot); -> LATCH if run=1, else IDLE.
REQ-024 run deasserted mid-frame: current frame completes; stop after DONE.
REQ-025 Input changes after LATCH ignored until next LATCH; no tearing.
REQ-026 Hit test: object covers pixel iff ox <= cx <= ox+W-1 and oy <= cy <= oy+H-1, compared at X_W+1 / Y_W+1 bits (no wrap); off-screen portions clipped.
REQ-027 Priority: man > enabled board with lowest index > BG_COLOUR; disabled board never drawn.
REQ-028 Frame period with run held 1: H_RES*V_RES + 2 cycles.
REQ-029 plot=0 and x/y/colour hold last value in IDLE and LATCH.

Reset
REQ-030 resetn=0 asynchronously: state IDLE, cx=cy=0, x=0, y=0, colour=0, plot=0, frame_start=0, frame_done=0, shadow registers 0.
REQ-031 Reset mid-frame aborts the frame; after release, first frame_start no earlier than 1 cycle after run sampled 1.

Verification
REQ-032 Defaults, run=1, man (10,20), boards at (0,50),(40,60),(80,70),(120,80), all enabled -> 19200 plots, colour at (11,22)=100, (5,50)=010, (0,0)=000, frame_done with plot of (159,119).
REQ-033 Man (30,60) overlapping board0 (20,60) -> (31,60)=100, (25,60)=010; board1 at same spot as board0, board0 disabled -> board1 drawn.
REQ-034 Board at (150,118), BOARD_W=24 -> pixels x 150..159, y 118..119 coloured, no wrap to x=0..13 or y=0.
REQ-035 man_x changed 100 cycles after frame_start -> frame uses old value; next frame uses new.
REQ-036 run dropped mid-scan -> frame finishes, DONE -> IDLE, plot stays 0; resetn pulse mid-scan -> all outputs 0 immediately.
REQ-037 Parameters H_RES=8, V_RES=4, NUM_BOARDS=2 -> 32 plots, frame period 34 cycles with run=1.

Source files
------------

// File: rtl/sprite_renderer.sv
// Raster renderer: walks every pixel of the frame once, colouring it from a man sprite
// and a set of board rectangles latched at frame start, and streams plot writes.
module sprite_renderer #(
   parameter int          H_RES        = 160,
   parameter int          V_RES        = 120,
   parameter int          X_W          = 8,
   parameter int          Y_W          = 7,
   parameter int          NUM_BOARDS   = 4,
   parameter int          MAN_W        = 4,
   parameter int          MAN_H        = 6,
   parameter int          BOARD_W      = 24,
   parameter int          BOARD_H      = 2,
   parameter logic [2:0]  MAN_COLOUR   = 3'b100,
   parameter logic [2:0]  BOARD_COLOUR = 3'b010,
   parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       run,
   input  logic [X_W-1:0]             man_x,
   input  logic [Y_W-1:0]             man_y,
   input  logic [NUM_BOARDS*X_W-1:0]  boards_x,
   input  logic [NUM_BOARDS*Y_W-1:0]  boards_y,
   input  logic [NUM_BOARDS-1:0]      board_en,
   output logic [X_W-1:0]             x,
   output logic [Y_W-1:0]             y,
   output logic [2:0]                 colour,
   output logic                       plot,
   output logic                       frame_start,
   output logic                       frame_done
);

   typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;

   localparam logic [X_W-1:0] X_LAST  = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_RES - 1);
   localparam logic [X_W:0]   MX_SPAN = (X_W+1)'(MAN_W - 1);
   localparam logic [Y_W:0]   MY_SPAN = (Y_W+1)'(MAN_H - 1);
   localparam logic [X_W:0]   BX_SPAN = (X_W+1)'(BOARD_W - 1);
   localparam logic [Y_W:0]   BY_SPAN = (Y_W+1)'(BOARD_H - 1);

   state_t                    state_q, state_d;
   logic [X_W-1:0]            cx_q, cx_d;
   logic [Y_W-1:0]            cy_q, cy_d;
   logic [X_W-1:0]            man_x_q, man_x_d;
   logic [Y_W-1:0]            man_y_q, man_y_d;
   logic [NUM_BOARDS*X_W-1:0] bx_q, bx_d;
   logic [NUM_BOARDS*Y_W-1:0] by_q, by_d;
   logic [NUM_BOARDS-1:0]     en_q, en_d;
   logic [X_W-1:0]            x_q, x_d;
   logic [Y_W-1:0]            y_q, y_d;
   logic [2:0]                colour_q, colour_d;
   logic                      plot_q, plot_d;

   // Hit tests run one bit wider than the coordinates so a rectangle hanging
   // off the right/bottom edge is clipped instead of wrapping to 0.
   logic [X_W:0]          cx_ext, man_x_lo, man_x_hi;
   logic [Y_W:0]          cy_ext, man_y_lo, man_y_hi;
   logic                  man_hit;
   logic [NUM_BOARDS-1:0] board_hit;
   logic [2:0]            shade;

   assign cx_ext   = {1'b0, cx_q};
   assign cy_ext   = {1'b0, cy_q};
   assign man_x_lo = {1'b0, man_x_q};
   assign man_y_lo = {1'b0, man_y_q};
   assign man_x_hi = man_x_lo + MX_SPAN;
   assign man_y_hi = man_y_lo + MY_SPAN;
   assign man_hit  = (cx_ext >= man_x_lo) && (cx_ext <= man_x_hi) &&
                     (cy_ext >= man_y_lo) && (cy_ext <= man_y_hi);

   for (genvar i = 0; i < NUM_BOARDS; i++) begin : g_board
      logic [X_W:0] lo_x, hi_x;
      logic [Y_W:0] lo_y, hi_y;
      assign lo_x = {1'b0, bx_q[i*X_W +: X_W]};
      assign lo_y = {1'b0, by_q[i*Y_W +: Y_W]};
      assign hi_x = lo_x + BX_SPAN;
      assign hi_y = lo_y + BY_SPAN;
      assign board_hit[i] = en_q[i] && (cx_ext >= lo_x) && (cx_ext <= hi_x) &&
                            (cy_ext >= lo_y) && (cy_ext <= hi_y);
   end

   // All boards share one colour, so "lowest enabled index wins" reduces to any-hit.
   always_comb begin
      shade = BG_COLOUR;
      if (|board_hit) shade = BOARD_COLOUR;
      if (man_hit)    shade = MAN_COLOUR;
   end

   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      man_x_d  = man_x_q;
      man_y_d  = man_y_q;
      bx_d     = bx_q;
      by_d     = by_q;
      en_d     = en_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      unique case (state_q)
         IDLE: if (run) state_d = LATCH;
         LATCH: begin
            man_x_d = man_x;
            man_y_d = man_y;
            bx_d    = boards_x;
            by_d    = boards_y;
            en_d    = board_en;
            cx_d    = '0;
            cy_d    = '0;
            state_d = SCAN;
         end
         SCAN: begin
            x_d      = cx_q;
            y_d      = cy_q;
            colour_d = shade;
            plot_d   = 1'b1;
            if (cx_q == X_LAST) begin
               cx_d = '0;
               if (cy_q == Y_LAST) begin
                  cy_d    = '0;
                  state_d = DONE;
               end else begin
                  cy_d = cy_q + 1'b1;
               end
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         DONE: state_d = run ? LATCH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cx_q     <= '0;
         cy_q     <= '0;
         man_x_q  <= '0;
         man_y_q  <= '0;
         bx_q     <= '0;
         by_q     <= '0;
         en_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         man_x_q  <= man_x_d;
         man_y_q  <= man_y_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         en_q     <= en_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
      end
   end

   // The last pixel's plot lands in DONE, so frame_done lines up with it.
   assign frame_start = (state_q == LATCH);
   assign frame_done  = (state_q == DONE);
   assign x           = x_q;
   assign y           = y_q;
   assign colour      = colour_q;
   assign plot        = plot_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: full-frame scoreboard on the default-size instance,
// plus a tiny 8x4 instance checking plot count, period and raster contents.
module tb_sprite_renderer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, run, run2;
   logic [7:0]  man_x;
   logic [6:0]  man_y;
   logic [31:0] boards_x;
   logic [27:0] boards_y;
   logic [3:0]  board_en;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot, frame_start, frame_done;

   logic [3:0]  man_x2;
   logic [2:0]  man_y2;
   logic [7:0]  boards_x2;
   logic [5:0]  boards_y2;
   logic [1:0]  board_en2;
   logic [3:0]  x2;
   logic [2:0]  y2;
   logic [2:0]  colour2;
   logic        plot2, fs2, fd2;

   sprite_renderer dut (
      .clk(clk), .resetn(resetn), .run(run), .man_x(man_x), .man_y(man_y),
      .boards_x(boards_x), .boards_y(boards_y), .board_en(board_en),
      .x(x), .y(y), .colour(colour), .plot(plot),
      .frame_start(frame_start), .frame_done(frame_done)
   );

   sprite_renderer #(.H_RES(8), .V_RES(4), .X_W(4), .Y_W(3), .NUM_BOARDS(2)) dut_small (
      .clk(clk), .resetn(resetn), .run(run2), .man_x(man_x2), .man_y(man_y2),
      .boards_x(boards_x2), .boards_y(boards_y2), .board_en(board_en2),
      .x(x2), .y(y2), .colour(colour2), .plot(plot2),
      .frame_start(fs2), .frame_done(fd2)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int c_mx, c_my;
   int c_bx[4];
   int c_by[4];
   logic [3:0] c_en;
   int s2_bx[4] = '{0, 5, 0, 0};
   int s2_by[4] = '{3, 0, 0, 0};

   logic [17:0] sbq[$];
   logic [2:0]  fb[0:159][0:119];
   bit sb_on = 0;
   int nfs = 0, nfd = 0, cur_plots = 0, cur_mis = 0;
   int fs_cyc[8], f_plots[8], f_mis[8];
   logic f_done_ok[8];

   int n2 = 0, k2 = 0, mis2 = 0;
   int s2_cyc[2], p2[2];

   function automatic logic [2:0] model(int px, int py, int mx, int my, int bx[4], int by[4],
                                        logic [3:0] en, int nb);
      if (px >= mx && px <= mx + 3 && py >= my && py <= my + 5) return 3'b100;
      for (int i = 0; i < nb; i++)
         if (en[i] && px >= bx[i] && px <= bx[i] + 23 && py >= by[i] && py <= by[i] + 1)
            return 3'b010;
      return 3'b000;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(int mx, int my, int b0x, int b0y, int b1x, int b1y,
                          int b2x, int b2y, int b3x, int b3y, logic [3:0] en);
      c_mx = mx; c_my = my; c_en = en;
      c_bx = '{b0x, b1x, b2x, b3x};
      c_by = '{b0y, b1y, b2y, b3y};
      man_x    = 8'(mx);
      man_y    = 7'(my);
      boards_x = {8'(b3x), 8'(b2x), 8'(b1x), 8'(b0x)};
      boards_y = {7'(b3y), 7'(b2y), 7'(b1y), 7'(b0y)};
      board_en = en;
   endtask

   task automatic push_frame();
      for (int py = 0; py < 120; py++)
         for (int px = 0; px < 160; px++)
            sbq.push_back({8'(px), 7'(py), model(px, py, c_mx, c_my, c_bx, c_by, c_en, 4)});
   endtask

   // sel 0: wait for frame_start count, sel 1: frame_done count
   task automatic wait_cnt(int sel, int n, int budget, string tag);
      int i = 0;
      while (((sel == 0) ? nfs : nfd) < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      chk(tag, (((sel == 0) ? nfs : nfd) >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_frame(int f, string name);
      chk({name, "_plots"}, f_plots[f], 19200);
      chk({name, "_sb"}, f_mis[f], 0);
      chk({name, "_done_last"}, {31'd0, f_done_ok[f]}, 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor for the default instance: records frame stats and pops the scoreboard.
   initial forever begin
      logic [17:0] e;
      @(negedge clk);
      if (frame_start) begin
         if (nfs < 8) fs_cyc[nfs] = cyc;
         nfs++;
         cur_plots = 0;
         cur_mis = 0;
      end
      if (plot) begin
         cur_plots++;
         if (x < 160 && y < 120) fb[x][y] = colour;
         if (sb_on) begin
            if (sbq.size() == 0) cur_mis++;
            else begin
               e = sbq.pop_front();
               if ({x, y, colour} !== e) cur_mis++;
            end
         end
      end
      if (frame_done) begin
         if (nfd < 8) begin
            f_plots[nfd]   = cur_plots;
            f_mis[nfd]     = cur_mis;
            f_done_ok[nfd] = plot && x == 8'd159 && y == 7'd119;
         end
         nfd++;
      end
   end

   // Monitor for the small instance: first two frames only.
   initial forever begin
      @(negedge clk);
      if (fs2) begin
         if (n2 < 2) begin
            s2_cyc[n2] = cyc;
            p2[n2] = 0;
         end
         n2++;
         k2 = 0;
      end
      if (plot2 && (n2 == 1 || n2 == 2)) begin
         p2[n2-1]++;
         if (int'(x2) != k2 % 8 || int'(y2) != k2 / 8 ||
             colour2 !== model(k2 % 8, k2 / 8, 2, 1, s2_bx, s2_by, 4'b0011, 2))
            mis2++;
         k2++;
      end
   end

   initial begin
      int bad;
      resetn = 1'b0; run = 1'b0; run2 = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      man_x2 = 4'd2; man_y2 = 3'd1;
      boards_x2 = {4'd5, 4'd0}; boards_y2 = {3'd0, 3'd3}; board_en2 = 2'b11;
      repeat (2) @(negedge clk);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      chk("rst_plot", plot, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_fd", frame_done, 0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_plot", plot, 0);

      // Frame 1: config A. Config B applied mid-frame must only affect frame 2.
      set_cfg(10, 20, 0, 50, 40, 60, 80, 70, 120, 80, 4'b1111);
      push_frame();
      sb_on = 1;
      run = 1'b1;
      run2 = 1'b1;
      wait_cnt(0, 1, 10, "f1_start_seen");
      repeat (100) @(negedge clk);
      set_cfg(30, 60, 20, 60, 20, 60, 150, 118, 120, 80, 4'b1111);
      push_frame();
      wait_cnt(1, 1, 20000, "f1_done_seen");
      check_frame(0, "f1");
      chk("f1_man", fb[11][22], 3'b100);
      chk("f1_board0", fb[5][50], 3'b010);
      chk("f1_bg", fb[0][0], 3'b000);
      chk("small_period", s2_cyc[1] - s2_cyc[0], 34);
      chk("small_plots0", p2[0], 32);
      chk("small_plots1", p2[1], 32);
      chk("small_pixels", mis2, 0);

      // Frame 2: config B; config C (board0 disabled) applied mid-frame.
      wait_cnt(0, 2, 10, "f2_start_seen");
      chk("period_1_2", fs_cyc[1] - fs_cyc[0], 19202);
      repeat (100) @(negedge clk);
      set_cfg(30, 60, 20, 60, 20, 60, 150, 118, 120, 80, 4'b0110);
      push_frame();
      wait_cnt(1, 2, 20000, "f2_done_seen");
      check_frame(1, "f2");
      chk("f2_man_over_board", fb[31][60], 3'b100);
      chk("f2_board_edge", fb[25][60], 3'b010);
      chk("f2_old_man_gone", fb[11][22], 3'b000);
      chk("f2_clip_lo", fb[150][118], 3'b010);
      chk("f2_clip_hi", fb[159][119], 3'b010);
      chk("f2_left_of_clip", fb[149][118], 3'b000);
      chk("f2_no_xwrap", fb[5][118], 3'b000);
      chk("f2_no_ywrap", fb[5][0], 3'b000);

      // Frame 3: drop run mid-scan; frame must still complete, then go quiet.
      wait_cnt(0, 3, 10, "f3_start_seen");
      chk("period_2_3", fs_cyc[2] - fs_cyc[1], 19202);
      repeat (50) @(negedge clk);
      run = 1'b0;
      wait_cnt(1, 3, 20000, "f3_done_seen");
      check_frame(2, "f3");
      chk("f3_board1_drawn", fb[25][60], 3'b010);
      chk("f3_disabled_board", fb[125][80], 3'b000);
      chk("f3_man", fb[31][60], 3'b100);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (plot || frame_start || frame_done) bad++;
      end
      chk("stopped_quiet", bad, 0);
      chk("sb_empty", sbq.size(), 0);

      // Reset mid-scan clears outputs without waiting for a clock edge.
      sb_on = 0;
      run = 1'b1;
      wait_cnt(0, 4, 10, "f4_start_seen");
      repeat (30) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_plot", plot, 0);
      chk("arst_x", x, 0);
      chk("arst_y", y, 0);
      chk("arst_colour", colour, 0);
      chk("arst_fs", frame_start, 0);
      chk("arst_fd", frame_done, 0);
      run = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (frame_start || plot) bad++;
      end
      chk("post_rst_idle", bad, 0);
      run = 1'b1;
      @(negedge clk);
      chk("restart_fs", frame_start, 1);
      chk("restart_latch_plot", plot, 0);
      @(negedge clk);
      chk("restart_fs_single", frame_start, 0);
      chk("restart_scan0_plot", plot, 0);
      @(negedge clk);
      chk("first_plot", plot, 1);
      chk("first_xy", {x, y}, 15'd0);
      resetn = 1'b0;
      run = 1'b0;
      run2 = 1'b0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
